// File: rtl/decoder_scan.sv
// decoder_scan -- registered SEL_W-to-2^SEL_W one-hot decoder with a
// three-input enable gate, selectable output polarity and an autonomous
// scan sequencer (dwell + break-before-make blanking).
//
// Ports
//   clk    in   sole clock, rising edge
//   rst_n  in   synchronous active-low reset
//   en     in   active-high enable (G1)
//   en_n   in   [1:0] active-low enables (G2A, G2B)
//   mode   in   0 = direct decode of sel, 1 = scan 0..last
//   sel    in   [SEL_W-1:0] index decoded in direct mode
//   last   in   [SEL_W-1:0] final index of the scan sequence
//   y      out  [2^SEL_W-1:0] registered decoded outputs
//   idx    out  [SEL_W-1:0] index currently (or most recently) driven
//   wrap   out  one-cycle pulse on the first cycle index 0 is shown after rollover

// Per-output slice: compares the shared next index against its own
// position and applies the output polarity.
module decoder_scan_lane #(
    parameter int SEL_W      = 3,
    parameter int LANE       = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             drive_i,
    input  logic [SEL_W-1:0] idx_i,
    output logic             y_o
);
    localparam logic [SEL_W-1:0] ME  = SEL_W'(LANE);
    localparam logic             POL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    logic hit;

    assign hit = drive_i && (idx_i == ME);
    assign y_o = hit ^ POL;
endmodule

module decoder_scan #(
    parameter int SEL_W      = 3,
    parameter int DWELL      = 4,
    parameter int BLANK      = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [1:0]              en_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [SEL_W-1:0]        last,
    output logic [(1<<SEL_W)-1:0]   y,
    output logic [SEL_W-1:0]        idx,
    output logic                    wrap
);
    localparam int N    = 1 << SEL_W;
    localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int PH_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [PH_W-1:0] DW_LAST = PH_W'(DWELL - 1);
    localparam logic [PH_W-1:0] BL_LAST = PH_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [N-1:0]    INACT   = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {
        ST_DIRECT = 2'd0,
        ST_ON     = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [SEL_W-1:0] idx_q,   idx_d;
    logic             wrap_q,  wrap_d;
    logic [N-1:0]     y_q,     y_d;

    logic             gate;
    logic             drive_d;   // next cycle shows onehot(idx_d)
    logic             roll;      // current index is at or past the end
    logic [SEL_W-1:0] idx_next;

    assign gate = en & ~en_n[0] & ~en_n[1];

    // idx > last can happen when last shrinks mid-scan; treat it as the
    // end of the sequence so the scan never runs past the new limit.
    assign roll     = (idx_q >= last);
    assign idx_next = roll ? '0 : idx_q + SEL_W'(1);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        drive_d = 1'b0;

        case (state_q)
            ST_DIRECT: begin
                if (mode) begin
                    // Scan always restarts from index 0 without a wrap.
                    state_d = ST_ON;
                    idx_d   = '0;
                    phase_d = '0;
                    drive_d = gate;
                end else begin
                    idx_d   = sel;
                    drive_d = gate;
                end
            end

            default: begin
                if (!mode) begin
                    // Leaving scan discards all sequencer state.
                    state_d = ST_DIRECT;
                    idx_d   = sel;
                    phase_d = '0;
                    drive_d = gate;
                end else if (!gate) begin
                    // Freeze: hold state/phase/idx, blank the outputs.
                    drive_d = 1'b0;
                end else if (state_q == ST_ON) begin
                    if (phase_q != DW_LAST) begin
                        phase_d = phase_q + PH_W'(1);
                        drive_d = 1'b1;
                    end else if (BLANK > 0) begin
                        state_d = ST_GAP;
                        phase_d = '0;
                    end else begin
                        idx_d   = idx_next;
                        phase_d = '0;
                        drive_d = 1'b1;
                        wrap_d  = roll;
                    end
                end else begin
                    if (phase_q != BL_LAST) begin
                        phase_d = phase_q + PH_W'(1);
                    end else begin
                        state_d = ST_ON;
                        idx_d   = idx_next;
                        phase_d = '0;
                        drive_d = 1'b1;
                        wrap_d  = roll;
                    end
                end
            end
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        decoder_scan_lane #(
            .SEL_W      (SEL_W),
            .LANE       (i),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_lane (
            .drive_i (drive_d),
            .idx_i   (idx_d),
            .y_o     (y_d[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_DIRECT;
            phase_q <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            y_q     <= INACT;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            y_q     <= y_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan. dut: defaults (DWELL=4, BLANK=1,
// active-low). dut2: DWELL=1, BLANK=0, active-high, sharing the inputs.
module tb_decoder_scan;
    logic       clk = 1'b0;
    logic       rst_n, en, mode;
    logic [1:0] en_n;
    logic [2:0] sel, last;
    logic [7:0] y, y2;
    logic [2:0] idx, idx2;
    logic       wrap, wrap2;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(3), .DWELL(4), .BLANK(1), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .en_n(en_n), .mode(mode),
        .sel(sel), .last(last), .y(y), .idx(idx), .wrap(wrap)
    );

    decoder_scan #(.SEL_W(3), .DWELL(1), .BLANK(0), .ACTIVE_LOW(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .en_n(en_n), .mode(mode),
        .sel(sel), .last(last), .y(y2), .idx(idx2), .wrap(wrap2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mode = 1'b1; en = 1'b1; en_n = 2'b00; sel = 3'd5; last = 3'd3;
        tick; tick;
        checks++;
        if ({y, idx, wrap} !== {8'hFF, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset dut y=%h idx=%0d wrap=%b want y=ff idx=0 wrap=0", y, idx, wrap);
        end
        checks++;
        if ({y2, idx2, wrap2} !== {8'h00, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset dut2 y=%h idx=%0d wrap=%b want y=00 idx=0 wrap=0", y2, idx2, wrap2);
        end
        mode = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_direct;
        logic [7:0] oh;
        mode = 1'b0; en = 1'b1; en_n = 2'b00;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick;
            oh = 8'd1 << s;
            checks++;
            if ({y, idx, wrap} !== {~oh, 3'(s), 1'b0}) begin
                errors++;
                $display("FAIL direct sel=%0d y=%h idx=%0d wrap=%b want y=%h", s, y, idx, wrap, ~oh);
            end
            checks++;
            if (y2 !== oh) begin
                errors++;
                $display("FAIL direct2 sel=%0d y=%h want %h", s, y2, oh);
            end
        end
        en_n = 2'b01; tick;
        checks++;
        if (y !== 8'hFF) begin errors++; $display("FAIL gate_g2a y=%h want ff", y); end
        en_n = 2'b10; tick;
        checks++;
        if (y !== 8'hFF) begin errors++; $display("FAIL gate_g2b y=%h want ff", y); end
        en_n = 2'b00; en = 1'b0; tick;
        checks++;
        if (y !== 8'hFF) begin errors++; $display("FAIL gate_g1 y=%h want ff", y); end
        en = 1'b1; sel = 3'd2; tick;
        checks++;
        if (y !== 8'hFB) begin errors++; $display("FAIL gate_back y=%h want fb", y); end
    endtask

    // last=3: 4 cycles per index, 1 blank, 20-cycle period, then index 0 with wrap.
    task automatic test_scan;
        logic [7:0] ey;
        logic [2:0] ei;
        logic       ew;
        int         k;
        mode = 1'b0; en = 1'b1; en_n = 2'b00; last = 3'd3; tick;
        mode = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            tick;
            k  = c % 20;
            ey = (k % 5 < 4) ? ~(8'd1 << (k / 5)) : 8'hFF;
            ei = 3'(k / 5);
            ew = (c == 20);
            checks++;
            if ({y, idx, wrap} !== {ey, ei, ew}) begin
                errors++;
                $display("FAIL scan c=%0d y=%h idx=%0d wrap=%b want y=%h idx=%0d wrap=%b",
                         c, y, idx, wrap, ey, ei, ew);
            end
        end
    endtask

    // Continues from index 0, phase 0 left by test_scan.
    task automatic test_freeze;
        logic [7:0] ey [9];
        ey = '{8'hFB, 8'hFB, 8'hFF, 8'hF7, 8'hF7, 8'hF7, 8'hF7, 8'hFF, 8'hFE};
        for (int c = 0; c < 11; c++) tick;
        checks++;
        if ({y, idx} !== {8'hFB, 3'd2}) begin
            errors++;
            $display("FAIL freeze_pre y=%h idx=%0d want y=fb idx=2", y, idx);
        end
        en = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick;
            checks++;
            if ({y, idx, wrap} !== {8'hFF, 3'd2, 1'b0}) begin
                errors++;
                $display("FAIL freeze c=%0d y=%h idx=%0d wrap=%b want y=ff idx=2 wrap=0", c, y, idx, wrap);
            end
        end
        en = 1'b1;
        for (int c = 0; c < 9; c++) begin
            tick;
            checks++;
            if ({y, wrap} !== {ey[c], (c == 8)}) begin
                errors++;
                $display("FAIL resume c=%0d y=%h wrap=%b want y=%h wrap=%b", c, y, wrap, ey[c], (c == 8));
            end
        end
    endtask

    task automatic test_mode_last;
        logic [7:0] ey [4];
        ey = '{8'hDF, 8'hDF, 8'hDF, 8'hFF};
        mode = 1'b0; last = 3'd7; tick;
        mode = 1'b1; tick;
        for (int c = 0; c < 25; c++) tick;
        checks++;
        if ({y, idx} !== {8'hDF, 3'd5}) begin
            errors++;
            $display("FAIL last_pre y=%h idx=%0d want y=df idx=5", y, idx);
        end
        last = 3'd1;
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++;
            if ({y, wrap} !== {ey[c], 1'b0}) begin
                errors++;
                $display("FAIL last_dwell c=%0d y=%h wrap=%b want y=%h wrap=0", c, y, wrap, ey[c]);
            end
        end
        tick;
        checks++;
        if ({y, idx, wrap} !== {8'hFE, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL last_wrap y=%h idx=%0d wrap=%b want y=fe idx=0 wrap=1", y, idx, wrap);
        end
        for (int c = 0; c < 4; c++) tick;
        checks++;
        if (y !== 8'hFF) begin errors++; $display("FAIL gap_pre y=%h want ff", y); end
        mode = 1'b0; sel = 3'd6; tick;
        checks++;
        if ({y, idx, wrap} !== {8'hBF, 3'd6, 1'b0}) begin
            errors++;
            $display("FAIL gap_exit y=%h idx=%0d wrap=%b want y=bf idx=6 wrap=0", y, idx, wrap);
        end
        mode = 1'b1; tick;
        checks++;
        if ({y, idx, wrap} !== {8'hFE, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reentry y=%h idx=%0d wrap=%b want y=fe idx=0 wrap=0", y, idx, wrap);
        end
    endtask

    // last=0: index 0 repeats, wrap at the start of each period after the first.
    task automatic test_last0;
        logic [7:0] ey;
        logic       ew;
        mode = 1'b0; last = 3'd0; tick;
        mode = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            tick;
            ey = (c % 5 < 4) ? 8'hFE : 8'hFF;
            ew = (c > 0) && (c % 5 == 0);
            checks++;
            if ({y, idx, wrap} !== {ey, 3'd0, ew}) begin
                errors++;
                $display("FAIL last0 c=%0d y=%h idx=%0d wrap=%b want y=%h idx=0 wrap=%b", c, y, idx, wrap, ey, ew);
            end
        end
    endtask

    // dut2: back-to-back one-hot steps with no blanking, wrap every 8 cycles.
    task automatic test_back_to_back;
        logic [7:0] ey;
        logic       ew;
        mode = 1'b0; en = 1'b1; en_n = 2'b00; last = 3'd7; tick;
        mode = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            tick;
            ey = 8'd1 << (c % 8);
            ew = (c > 0) && (c % 8 == 0);
            checks++;
            if ({y2, idx2, wrap2} !== {ey, 3'(c % 8), ew}) begin
                errors++;
                $display("FAIL fast c=%0d y=%h idx=%0d wrap=%b want y=%h idx=%0d wrap=%b",
                         c, y2, idx2, wrap2, ey, c % 8, ew);
            end
        end
    endtask

    task automatic test_midscan_reset;
        rst_n = 1'b0; tick;
        checks++;
        if ({y, idx, wrap, y2, wrap2} !== {8'hFF, 3'd0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL midreset y=%h idx=%0d wrap=%b y2=%h wrap2=%b want ff 0 0 00 0", y, idx, wrap, y2, wrap2);
        end
        rst_n = 1'b1; tick;
        checks++;
        if ({y, idx, wrap} !== {8'hFE, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL post_reset y=%h idx=%0d wrap=%b want y=fe idx=0 wrap=0", y, idx, wrap);
        end
    endtask

    initial begin
        test_reset;
        test_direct;
        test_scan;
        test_freeze;
        test_mode_last;
        test_last0;
        test_back_to_back;
        test_midscan_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered successor to the team's 3-to-8 inverting decoder: a SEL_W-to-2^SEL_W one-hot decoder with the classic three-input enable gate (one active-high, two active-low), selectable output polarity, and an autonomous scan mode. In scan mode the block steps its own index through 0..last with a programmable dwell and break-before-make blanking, for driving LED/keyboard matrix rows and chip-select sequencing without an external counter.

## Interface
Parameters:
- SEL_W, 3, select width; output count N = 2^SEL_W (1..6).
- DWELL, 4, cycles an index stays active in scan mode (>= 1).
- BLANK, 1, all-inactive cycles between scan steps (>= 0).
- ACTIVE_LOW, 1, 1 = selected output driven 0, others 1; 0 = inverse.

Ports:
- clk  in  1  sole clock, all state on rising edge.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- en  in  1  active-high enable (G1).
- en_n  in  2  active-low enables (G2A, G2B).
- mode  in  1  0 = direct decode, 1 = scan.
- sel  in  SEL_W  index to decode in direct mode.
- last  in  SEL_W  final index of scan sequence.
- y  out  N  decoded outputs, registered.
- idx  out  SEL_W  index currently (or last) driven.
- wrap  out  1  one-cycle pulse on scan rollover to index 0.

## Operation
- gate = en & ~en_n[0] & ~en_n[1]. Inactive level = ACTIVE_LOW ? 1 : 0 on every y bit.
- States: DIRECT, ON, GAP. Counters: phase (fits max(DWELL,BLANK)), idx.
- DIRECT (mode=0): y <= gate ? onehot(sel) : all inactive; idx <= sel. No wrap. mode=1 -> ON, idx=0, phase=0.
- ON: y = onehot(idx) when gate, else all inactive. phase counts 0..DWELL-1; at DWELL-1: BLANK>0 -> GAP, else advance idx directly, stay ON.
- GAP: y all inactive; phase 0..BLANK-1; at BLANK-1 -> ON with next idx.
- Advance: idx >= last -> idx=0 and wrap pulses on the first ON cycle of index 0; otherwise idx+1. last changed mid-scan with idx > last: next advance goes to 0 (wrap).
- gate low in scan mode: outputs inactive, phase/idx/state frozen; resumes exactly where stopped when gate returns.
- mode=0 sampled in ON/GAP: next cycle DIRECT behaviour; scan state discarded. Re-entry always starts at index 0, no wrap.
- last=0: index 0 repeats, wrap every DWELL+BLANK cycles after the first period.

## Timing
- Reset (rst_n=0 at an edge): state DIRECT, y all inactive, idx=0, wrap=0, phase=0. Dominates all inputs; mid-scan reset aborts immediately.
- Direct latency: 1 cycle from sel/enable change to y.
- Scan entry: mode=1 sampled at edge t -> index 0 active at t+1.
- Scan period per index: DWELL+BLANK cycles; full sequence (last+1)*(DWELL+BLANK).
- No two y bits ever active in the same cycle; with BLANK>=1 at least one all-inactive cycle between distinct active indices.
- wrap is high exactly one cycle, aligned with y showing index 0; never high in DIRECT or while gate low.

## Test plan
- Reset: rst_n=0 two cycles with mode=1 -> y=8'hFF, idx=0, wrap=0 (SEL_W=3, ACTIVE_LOW=1).
- Direct sweep: en=1, en_n=0, sel=0..7 -> y one cycle later = ~(1<<sel); en_n=2'b01 or en=0 -> y=8'hFF.
- Scan defaults, last=3: y pattern FE x4, FF x1, FD x4, FF, FB x4, FF, F7 x4, FF, then FE with wrap=1 for one cycle; period 20 cycles.
- Freeze: drop en for 7 cycles mid-dwell of idx 2 -> y=FF for 7 cycles, then idx 2 resumes remaining dwell cycles; no extra wrap.
- Mode/last changes: last 7->1 while idx=5 -> next step idx 0 with wrap; mode=0 mid-GAP with sel=6 -> y=BF next cycle.
- BLANK=0, ACTIVE_LOW=0, DWELL=1, last=7: y=01,02,...,80,01 consecutive cycles, wrap every 8 cycles.
